// File: rtl/store_buffer_fwd_unit.sv
// Posted-write store buffer between MEM and data memory. Stores drain in FIFO order in the
// background, and loads that the buffered bytes fully cover are forwarded from the buffer.
module store_buffer_fwd_lane #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]      hit,
    input  logic [DEPTH-1:0][7:0] data,
    output logic                  sel,
    output logic [7:0]            fwd_byte
);
    // hit/data are age-ordered (index 0 = oldest), so the last hit wins
    always_comb begin
        sel      = 1'b0;
        fwd_byte = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                sel      = 1'b1;
                fwd_byte = data[i];
            end
        end
    end
endmodule

module store_buffer_fwd_unit #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_MEM_WRITE,
    input  logic        MEM_MEM_READ,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic        MEM_FWD_SEL,
    output logic [31:0] MEM_FWD_DATA,
    output logic        BUF_STALL,
    output logic        BUF_EMPTY,
    output logic        DMEM_WRITE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WRITE_DATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic        DMEM_BUSYWAIT
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    logic [DEPTH-1:0][29:0] ent_addr;
    logic [DEPTH-1:0][31:0] ent_data;
    logic [DEPTH-1:0][3:0]  ent_mask;
    logic [DEPTH-1:0]       ent_vld;
    logic [AW-1:0]          head, tail;
    logic [AW:0]            count;
    state_t                 state, state_nxt;

    logic [3:0]  acc_mask;
    logic [31:0] acc_lane;
    logic [1:0]  acc_off;
    logic        full, enq, retire, covered, partial;

    // Access decode shared by stores (mask + lane data) and loads (required mask + offset)
    always_comb begin
        acc_mask = 4'b1111;
        acc_lane = MEM_WRITE_DATA;
        acc_off  = 2'b00;
        case (MEM_FUNCT3[1:0])
            2'b00: begin
                acc_mask = 4'b0001 << MEM_ADDR[1:0];
                acc_lane = {4{MEM_WRITE_DATA[7:0]}};
                acc_off  = MEM_ADDR[1:0];
            end
            2'b01: begin
                acc_mask = MEM_ADDR[1] ? 4'b1100 : 4'b0011;
                acc_lane = {2{MEM_WRITE_DATA[15:0]}};
                acc_off  = {MEM_ADDR[1], 1'b0};
            end
            default: ;
        endcase
    end

    logic [DEPTH-1:0]           age_match;
    logic [3:0][DEPTH-1:0]      lane_hit;
    logic [3:0][DEPTH-1:0][7:0] lane_byte;
    logic [3:0]                 got;
    logic [31:0]                fwd_word, fwd_shift;

    always_comb begin
        age_match = '0;
        lane_hit  = '0;
        lane_byte = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_match[i] = ent_vld[head + AW'(i)] && (ent_addr[head + AW'(i)] == MEM_ADDR[31:2]);
            for (int b = 0; b < 4; b++) begin
                lane_hit[b][i]  = age_match[i] & ent_mask[head + AW'(i)][b];
                lane_byte[b][i] = ent_data[head + AW'(i)][8*b +: 8];
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        store_buffer_fwd_lane #(.DEPTH(DEPTH)) u_lane (
            .hit      (lane_hit[b]),
            .data     (lane_byte[b]),
            .sel      (got[b]),
            .fwd_byte (fwd_word[8*b +: 8])
        );
    end

    assign covered   = ((got & acc_mask) == acc_mask);
    assign partial   = MEM_MEM_READ && (|(got & acc_mask)) && !covered;
    assign full      = (count == (AW+1)'(DEPTH));
    assign BUF_STALL = (MEM_MEM_WRITE && full) || partial;
    assign BUF_EMPTY = (count == '0);
    assign enq       = MEM_MEM_WRITE && !BUF_STALL;
    assign retire    = (state == WRITE) && !DMEM_BUSYWAIT;
    assign fwd_shift = fwd_word >> {acc_off, 3'b000};

    always_comb begin
        MEM_FWD_SEL  = MEM_MEM_READ && covered;
        MEM_FWD_DATA = '0;
        if (MEM_FWD_SEL) begin
            case (MEM_FUNCT3)
                3'b000:  MEM_FWD_DATA = {{24{fwd_shift[7]}}, fwd_shift[7:0]};
                3'b001:  MEM_FWD_DATA = {{16{fwd_shift[15]}}, fwd_shift[15:0]};
                3'b100:  MEM_FWD_DATA = {24'b0, fwd_shift[7:0]};
                3'b101:  MEM_FWD_DATA = {16'b0, fwd_shift[15:0]};
                default: MEM_FWD_DATA = fwd_shift;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
            state   <= IDLE;
        end else begin
            state <= state_nxt;
            if (enq) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + AW'(1);
            end
            if (retire) begin
                ent_vld[head] <= 1'b0;
                head          <= head + AW'(1);
            end
            case ({enq, retire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through ent_vld or the WRITE state
    always_ff @(posedge CLK) begin
        if (enq) begin
            ent_addr[tail] <= MEM_ADDR[31:2];
            ent_data[tail] <= acc_lane;
            ent_mask[tail] <= acc_mask;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (count != '0 && !MEM_MEM_READ) state_nxt = WRITE;
            WRITE: if (!DMEM_BUSYWAIT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DMEM_WRITE      = (state == WRITE);
        DMEM_ADDR       = '0;
        DMEM_WRITE_DATA = '0;
        DMEM_BYTE_EN    = '0;
        if (DMEM_WRITE) begin
            DMEM_ADDR       = {ent_addr[head], 2'b00};
            DMEM_WRITE_DATA = ent_data[head];
            DMEM_BYTE_EN    = ent_mask[head];
        end
    end
endmodule

// File: tb/tb_store_buffer_fwd_unit.sv
// Bench for store_buffer_fwd_unit: drain writes are scoreboarded against stores in issue order,
// loads are checked directly against bench-computed forwarding results.
module tb_store_buffer_fwd_unit;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MEM_MEM_WRITE = 1'b0;
    logic        MEM_MEM_READ = 1'b0;
    logic [2:0]  MEM_FUNCT3 = 3'b010;
    logic [31:0] MEM_ADDR = '0;
    logic [31:0] MEM_WRITE_DATA = '0;
    logic        DMEM_BUSYWAIT = 1'b0;
    logic        MEM_FWD_SEL, BUF_STALL, BUF_EMPTY, DMEM_WRITE;
    logic [31:0] MEM_FWD_DATA, DMEM_ADDR, DMEM_WRITE_DATA;
    logic [3:0]  DMEM_BYTE_EN;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100;

    store_buffer_fwd_unit #(.DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_MEM_WRITE(MEM_MEM_WRITE), .MEM_MEM_READ(MEM_MEM_READ),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_FWD_SEL(MEM_FWD_SEL), .MEM_FWD_DATA(MEM_FWD_DATA), .BUF_STALL(BUF_STALL),
        .BUF_EMPTY(BUF_EMPTY), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WRITE_DATA(DMEM_WRITE_DATA), .DMEM_BYTE_EN(DMEM_BYTE_EN), .DMEM_BUSYWAIT(DMEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } drain_t;

    drain_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mdl_mask(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'b0001 << a[1:0];
        if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] mdl_lane(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drain_t e;
        e.addr = {a[31:2], 2'b00};
        e.data = mdl_lane(f3, d);
        e.be   = mdl_mask(f3, a);
        sb.push_back(e);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        MEM_MEM_WRITE = 1'b1;
        MEM_FUNCT3 = f3;
        MEM_ADDR = a;
        MEM_WRITE_DATA = d;
        push_exp(f3, a, d);
        tick();
        MEM_MEM_WRITE = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic sel_exp, input logic [31:0] data_exp);
        MEM_MEM_READ = 1'b1;
        MEM_FUNCT3 = f3;
        MEM_ADDR = a;
        #1;
        chk({tag, "_sel"}, 32'(MEM_FWD_SEL), 32'(sel_exp));
        chk({tag, "_data"}, MEM_FWD_DATA, data_exp);
        chk({tag, "_stall"}, 32'(BUF_STALL), 32'd0);
        tick();
        MEM_MEM_READ = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 40 && !BUF_EMPTY; i++) tick();
        chk(tag, 32'(BUF_EMPTY), 32'd1);
    endtask

    // An accepted drain write is the DUT output event the scoreboard is matched against
    always @(negedge CLK) begin
        if (!RESET && DMEM_WRITE && !DMEM_BUSYWAIT) begin
            if (sb.size() == 0) begin
                chk("drain_extra", 32'(sb.size()), 32'd1);
            end else begin
                drain_t e;
                e = sb.pop_front();
                chk("drain_addr", DMEM_ADDR, e.addr);
                chk("drain_data", DMEM_WRITE_DATA, e.data);
                chk("drain_be", 32'(DMEM_BYTE_EN), 32'(e.be));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_empty", 32'(BUF_EMPTY), 32'd1);
        chk("rst_dwrite", 32'(DMEM_WRITE), 32'd0);
        chk("rst_stall", 32'(BUF_STALL), 32'd0);
        chk("rst_fwdsel", 32'(MEM_FWD_SEL), 32'd0);
        chk("rst_daddr", DMEM_ADDR, 32'd0);
        chk("rst_fwddata", MEM_FWD_DATA, 32'd0);
        tick();
        tick();
        RESET = 1'b0;

        // basic store and drain latency
        store(F_W, 32'h1000, 32'hDEADBEEF);
        chk("sw_notempty", 32'(BUF_EMPTY), 32'd0);
        chk("sw_nowrite_yet", 32'(DMEM_WRITE), 32'd0);
        tick();
        chk("sw_dwrite", 32'(DMEM_WRITE), 32'd1);
        chk("sw_daddr", DMEM_ADDR, 32'h1000);
        chk("sw_ddata", DMEM_WRITE_DATA, 32'hDEADBEEF);
        chk("sw_dbe", 32'(DMEM_BYTE_EN), 32'hF);
        tick();
        chk("sw_empty_after", 32'(BUF_EMPTY), 32'd1);

        // forwarding of sub-word loads with extension
        DMEM_BUSYWAIT = 1'b1;
        store(F_W, 32'h2000, 32'h11223344);
        load("lb_2003", F_B, 32'h2003, 1'b1, 32'h00000011);
        load("lh_2002", F_H, 32'h2002, 1'b1, 32'h00001122);
        store(F_B, 32'h2001, 32'h00000080);
        load("lbu_2001", F_BU, 32'h2001, 1'b1, 32'h00000080);
        load("lb_2001", F_B, 32'h2001, 1'b1, 32'hFFFFFF80);
        load("lw_merge", F_W, 32'h2000, 1'b1, 32'h11228044);
        load("lw_miss", F_W, 32'h2800, 1'b0, 32'h0);
        DMEM_BUSYWAIT = 1'b0;
        wait_empty("drain2_empty");

        // partial overlap stalls until the covering entry drains
        DMEM_BUSYWAIT = 1'b1;
        store(F_B, 32'h3000, 32'h000000AA);
        tick();
        MEM_MEM_READ = 1'b1;
        MEM_FUNCT3 = F_W;
        MEM_ADDR = 32'h3000;
        #1;
        chk("part_stall", 32'(BUF_STALL), 32'd1);
        chk("part_sel", 32'(MEM_FWD_SEL), 32'd0);
        chk("part_dwrite", 32'(DMEM_WRITE), 32'd1);
        tick();
        chk("part_stall_hold", 32'(BUF_STALL), 32'd1);
        DMEM_BUSYWAIT = 1'b0;
        tick();
        chk("part_stall_off", 32'(BUF_STALL), 32'd0);
        chk("part_sel_off", 32'(MEM_FWD_SEL), 32'd0);
        MEM_MEM_READ = 1'b0;
        wait_empty("drain3_empty");

        // youngest entry wins, before and after pointer wrap
        DMEM_BUSYWAIT = 1'b1;
        store(F_W, 32'h4000, 32'd1);
        store(F_W, 32'h4000, 32'd2);
        load("young", F_W, 32'h4000, 1'b1, 32'd2);
        DMEM_BUSYWAIT = 1'b0;
        wait_empty("drain4_empty");
        DMEM_BUSYWAIT = 1'b1;
        store(F_W, 32'h5000, 32'd9);
        store(F_W, 32'h4000, 32'd3);
        store(F_W, 32'h4000, 32'd4);
        load("young_wrap", F_W, 32'h4000, 1'b1, 32'd4);
        load("young_wrap_lh", F_H, 32'h4002, 1'b1, 32'd0);
        DMEM_BUSYWAIT = 1'b0;
        wait_empty("drain4w_empty");

        // full buffer: fifth store stalls, including in the retire cycle
        DMEM_BUSYWAIT = 1'b1;
        for (int k = 0; k < 4; k++) store(F_W, 32'h6000 + 32'(4 * k), 32'h600 + 32'(k));
        MEM_MEM_WRITE = 1'b1;
        MEM_FUNCT3 = F_W;
        MEM_ADDR = 32'h6010;
        MEM_WRITE_DATA = 32'h604;
        push_exp(F_W, 32'h6010, 32'h604);
        #1;
        chk("full_stall", 32'(BUF_STALL), 32'd1);
        tick();
        chk("full_stall_hold", 32'(BUF_STALL), 32'd1);
        DMEM_BUSYWAIT = 1'b0;
        #1;
        chk("full_stall_retire", 32'(BUF_STALL), 32'd1);
        tick();
        DMEM_BUSYWAIT = 1'b1;
        chk("full_stall_free", 32'(BUF_STALL), 32'd0);
        tick();
        MEM_MEM_WRITE = 1'b0;
        #1;
        MEM_MEM_WRITE = 1'b1;
        #1;
        chk("full_again", 32'(BUF_STALL), 32'd1);
        MEM_MEM_WRITE = 1'b0;
        DMEM_BUSYWAIT = 1'b0;
        wait_empty("drain5_empty");

        // reset in the middle of a drain
        DMEM_BUSYWAIT = 1'b1;
        store(F_W, 32'h7000, 32'h70);
        store(F_W, 32'h7004, 32'h71);
        store(F_W, 32'h7008, 32'h72);
        tick();
        chk("mid_dwrite", 32'(DMEM_WRITE), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        chk("arst_dwrite", 32'(DMEM_WRITE), 32'd0);
        chk("arst_empty", 32'(BUF_EMPTY), 32'd1);
        sb.delete();
        tick();
        tick();
        RESET = 1'b0;
        DMEM_BUSYWAIT = 1'b0;
        chk("post_rst_empty", 32'(BUF_EMPTY), 32'd1);
        load("post_rst_lw", F_W, 32'h7000, 1'b0, 32'd0);
        tick();
        chk("post_rst_nowrite", 32'(DMEM_WRITE), 32'd0);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer_fwd_unit.md
Name: store_buffer_fwd_unit

Overview:
- Posted-write store buffer between the MEM stage and data memory, with store-to-load forwarding.
- MEM-stage stores enqueue in one cycle and drain to data memory in the background.
- MEM-stage loads are served from buffered stores when the buffer fully covers the requested bytes, and stall on partial overlap.
- Complements the load-to-store path: this block forwards store data to subsequent loads.

Parameters:
- DEPTH, 4: number of buffer entries; a power of two, minimum 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- MEM_MEM_WRITE  input  1  store instruction valid in MEM stage.
- MEM_MEM_READ  input  1  load instruction valid in MEM stage; never asserted together with MEM_MEM_WRITE.
- MEM_FUNCT3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MEM_ADDR  input  32  byte address of the access.
- MEM_WRITE_DATA  input  32  store data, right-aligned.
- MEM_FWD_SEL  output  1  load fully satisfied from the buffer.
- MEM_FWD_DATA  output  32  forwarded load data, extended per MEM_FUNCT3.
- BUF_STALL  output  1  freeze the pipeline this cycle.
- BUF_EMPTY  output  1  no valid entries.
- DMEM_WRITE  output  1  drain request to data memory.
- DMEM_ADDR  output  32  word address of the head entry, bits [1:0] = 00.
- DMEM_WRITE_DATA  output  32  lane-aligned data of the head entry.
- DMEM_BYTE_EN  output  4  byte enables of the head entry.
- DMEM_BUSYWAIT  input  1  data memory busy; the write is accepted on the first edge with DMEM_WRITE=1 and DMEM_BUSYWAIT=0.

Behaviour:
- Reset (asynchronous):
  - Head pointer, tail pointer and count go to 0; all valid bits are cleared.
  - DMEM_WRITE, MEM_FWD_SEL and BUF_STALL go to 0; BUF_EMPTY goes to 1.
  - Data outputs go to 0.
  - Reset during a drain discards all entries and drops DMEM_WRITE immediately.
- Entry contents: word address [31:2], 32-bit lane-aligned data, 4-bit byte mask.
  - B: mask = 1 << addr[1:0]; data byte replicated to all lanes.
  - H: mask = 0011 or 1100, selected by addr[1]; addr[0] is ignored.
  - W: mask = 1111; addr[1:0] is ignored.
  - Misaligned accesses are not supported.
- Enqueue:
  - On an edge with MEM_MEM_WRITE=1 and BUF_STALL=0, write the tail entry and advance tail modulo DEPTH.
  - Latency: a store enqueued at edge N is visible to forwarding and to the drain logic from cycle N+1.
- Full:
  - BUF_STALL=1 whenever MEM_MEM_WRITE=1 and count==DEPTH, including cycles in which the head retires.
  - The store enqueues on the following edge.
- Drain FSM, states IDLE and WRITE:
  - IDLE -> WRITE when count>0 and MEM_MEM_READ=0. Drain never starts in a load cycle.
  - In WRITE, DMEM_WRITE=1 and DMEM_ADDR/DATA/BYTE_EN are driven from the head entry, held stable while DMEM_BUSYWAIT=1.
  - On acceptance, the head retires: head advances and count decrements.
  - After acceptance, go to IDLE, so each drain request is a new request.
  - MEM_MEM_READ arriving mid-WRITE does not abort the drain.
- Simultaneous enqueue and retire on the same edge: count is unchanged; the pointers both advance.
- Load lookup (combinational, over entries valid at the start of the cycle):
  - Compute the required byte mask from MEM_FUNCT3 and MEM_ADDR, as for stores.
  - For each required byte, the youngest valid entry with a matching word address and that mask bit supplies the byte. Youngest is determined by age relative to head, including after pointer wrap.
  - All required bytes supplied: MEM_FWD_SEL=1; MEM_FWD_DATA = selected bytes shifted to bit 0, sign-extended for B/H and zero-extended for BU/HU/W.
  - Some but not all bytes supplied: MEM_FWD_SEL=0 and BUF_STALL=1 until draining removes the overlap, then the load reads memory.
  - No bytes supplied: MEM_FWD_SEL=0 and no stall.
  - MEM_MEM_READ=0: MEM_FWD_SEL=0 and MEM_FWD_DATA=0.
- The entry retiring on the current edge still participates in the lookup for this cycle.

Test Plan:
- Reset, then SW 0x1000 <- 0xDEADBEEF with DMEM_BUSYWAIT=0 -> BUF_EMPTY=0 the next cycle; one cycle later DMEM_WRITE=1 with ADDR 0x1000, DATA 0xDEADBEEF, BYTE_EN 1111; after acceptance BUF_EMPTY=1.
- SW 0x2000 <- 0x11223344, then LB 0x2003 next cycle (BUSYWAIT held 1) -> MEM_FWD_SEL=1, MEM_FWD_DATA=0x00000011; LH 0x2002 -> 0x00001122; LBU after SB 0x2001 <- 0x80 -> 0x00000080, LB -> 0xFFFFFF80.
- SB 0x3000 <- 0xAA, then LW 0x3000 -> BUF_STALL=1 and MEM_FWD_SEL=0 until the entry drains, then BUF_STALL=0 and MEM_FWD_SEL=0.
- SW 0x4000 <- 1, then SW 0x4000 <- 2, then LW 0x4000 -> MEM_FWD_DATA=2, since the youngest entry wins; repeat the same sequence after the pointers wrap.
- BUSYWAIT held 1, DEPTH+1 stores -> BUF_STALL=1 on the 5th store; drop BUSYWAIT for one cycle -> head retires, 5th store enqueues on the next edge, count=4; drain order is address-FIFO.
- Assert RESET while DMEM_WRITE=1 with 3 entries queued -> DMEM_WRITE=0 asynchronously; after release, BUF_EMPTY=1 and a following LW forwards nothing.
